// File: rtl/argo_3stage.sv
// Three-process pipeline: input stage -> FIFO1 -> X1 register -> FIFO2 -> output register Z1.
// Every hop uses a valid/ready handshake, so with iready held low the pipe stores 2*DEPTH+2 words.
module argo_3stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ivalid,
    output logic             oready,
    input  logic [WIDTH-1:0] datain,
    output logic             ovalid,
    input  logic             iready,
    output logic [WIDTH-1:0] dataout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem1_q [DEPTH];
    logic [WIDTH-1:0] mem2_q [DEPTH];

    logic [AW-1:0]    wr1_ptr_q, wr1_ptr_d, rd1_ptr_q, rd1_ptr_d;
    logic [AW-1:0]    wr2_ptr_q, wr2_ptr_d, rd2_ptr_q, rd2_ptr_d;
    logic [CW-1:0]    cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [WIDTH-1:0] x1_q, x1_d, z1_q, z1_d;
    logic             x1_valid_q, x1_valid_d, ovalid_q, ovalid_d;

    logic full1, empty1, full2, empty2;
    logic push1, pop1, push2, load;

    assign full1  = (cnt1_q == CW'(DEPTH));
    assign empty1 = (cnt1_q == '0);
    assign full2  = (cnt2_q == CW'(DEPTH));
    assign empty2 = (cnt2_q == '0);

    // A full FIFO refuses a push even when it pops in the same cycle.
    assign oready = rst & ~full1;
    assign push1  = ivalid & oready;
    assign push2  = x1_valid_q & ~full2;
    assign pop1   = ~empty1 & (~x1_valid_q | push2);
    assign load   = ~empty2 & (~ovalid_q | iready);

    assign ovalid  = ovalid_q;
    assign dataout = z1_q;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        wr1_ptr_d  = wr1_ptr_q;
        rd1_ptr_d  = rd1_ptr_q;
        wr2_ptr_d  = wr2_ptr_q;
        rd2_ptr_d  = rd2_ptr_q;
        cnt1_d     = cnt1_q;
        cnt2_d     = cnt2_q;
        x1_d       = x1_q;
        x1_valid_d = x1_valid_q;
        z1_d       = z1_q;
        ovalid_d   = ovalid_q;

        if (push1) wr1_ptr_d = wr1_ptr_q + AW'(1);
        if (pop1)  rd1_ptr_d = rd1_ptr_q + AW'(1);
        if (push2) wr2_ptr_d = wr2_ptr_q + AW'(1);
        if (load)  rd2_ptr_d = rd2_ptr_q + AW'(1);

        case ({push1, pop1})
            2'b10:   cnt1_d = cnt1_q + CW'(1);
            2'b01:   cnt1_d = cnt1_q - CW'(1);
            default: ;
        endcase

        case ({push2, load})
            2'b10:   cnt2_d = cnt2_q + CW'(1);
            2'b01:   cnt2_d = cnt2_q - CW'(1);
            default: ;
        endcase

        if (pop1) begin
            x1_d       = mem1_q[rd1_ptr_q];
            x1_valid_d = 1'b1;
        end else if (push2) begin
            x1_valid_d = 1'b0;
        end

        // dataout keeps its last value when the output drains without a reload.
        if (load) begin
            z1_d     = mem2_q[rd2_ptr_q];
            ovalid_d = 1'b1;
        end else if (iready) begin
            ovalid_d = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr1_ptr_q  <= '0;
            rd1_ptr_q  <= '0;
            wr2_ptr_q  <= '0;
            rd2_ptr_q  <= '0;
            cnt1_q     <= '0;
            cnt2_q     <= '0;
            x1_q       <= '0;
            x1_valid_q <= 1'b0;
            z1_q       <= '0;
            ovalid_q   <= 1'b0;
        end else begin
            wr1_ptr_q  <= wr1_ptr_d;
            rd1_ptr_q  <= rd1_ptr_d;
            wr2_ptr_q  <= wr2_ptr_d;
            rd2_ptr_q  <= rd2_ptr_d;
            cnt1_q     <= cnt1_d;
            cnt2_q     <= cnt2_d;
            x1_q       <= x1_d;
            x1_valid_q <= x1_valid_d;
            z1_q       <= z1_d;
            ovalid_q   <= ovalid_d;
        end
    end

    // NOTE: storage arrays are not reset; empty counts guarantee stale entries are never read.
    always_ff @(posedge clk) begin
        if (push1) mem1_q[wr1_ptr_q] <= datain;
        if (push2) mem2_q[wr2_ptr_q] <= x1_q;
    end

endmodule

// File: tb/tb_argo_3stage.sv
// Bench for argo_3stage: table-driven fill/drain vectors, hand-written latency, stream,
// stall and reset sequences, with a scoreboard queue checked at every output handshake.
module tb_argo_3stage;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             ivalid;
    logic             oready;
    logic [WIDTH-1:0] datain;
    logic             ovalid;
    logic             iready;
    logic [WIDTH-1:0] dataout;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] sb[$];
    logic             stall_seen = 1'b0;
    logic [WIDTH-1:0] held_data  = '0;

    typedef struct {
        logic             ivalid;
        logic [WIDTH-1:0] data;
        logic             iready;
        logic             exp_oready;
        logic             chk;
    } vec_t;

    vec_t tbl[$];

    argo_3stage #(.WIDTH(WIDTH), .DEPTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .ivalid (ivalid),
        .oready (oready),
        .datain (datain),
        .ovalid (ovalid),
        .iready (iready),
        .dataout(dataout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one cycle of inputs; the expected accept decides what enters the scoreboard.
    task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic ir,
                         input logic exp_or, input logic chk);
        ivalid = iv;
        datain = d;
        iready = ir;
        if (iv && exp_or) sb.push_back(d);
        @(negedge clk);
        if (chk) check("oready", 32'(oready), 32'(exp_or));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (stall_seen) begin
                check("hold_valid", 32'(ovalid), 32'd1);
                check("hold_data", dataout, held_data);
            end
            if (ovalid && iready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got %h expected none", dataout);
                end else begin
                    check("sb_data", dataout, sb.pop_front());
                end
            end
            stall_seen = ovalid && !iready;
            held_data  = dataout;
        end else begin
            stall_seen = 1'b0;
        end
    end

    initial begin
        // Fill with iready=0: ten words fit, the eleventh and twelfth are refused.
        for (int i = 1; i <= 12; i++)
            tbl.push_back('{1'b1, WIDTH'(i), 1'b0, (i <= 10), 1'b1});
        for (int i = 0; i < 20; i++)
            tbl.push_back('{1'b0, '0, 1'b1, 1'b0, 1'b0});

        rst    = 1'b0;
        ivalid = 1'b0;
        datain = '0;
        iready = 1'b0;
        #12;
        check("rst_oready", 32'(oready), 32'd0);
        check("rst_ovalid", 32'(ovalid), 32'd0);
        check("rst_dataout", dataout, 32'd0);
        rst = 1'b1;
        #1;
        check("release_oready", 32'(oready), 32'd1);

        // Latency: accepts at edges 1 and 2, outputs after edges 4 and 5.
        ivalid = 1'b1; datain = 32'h55; iready = 1'b1; sb.push_back(32'h55);
        @(posedge clk); #1;
        datain = 32'h25; sb.push_back(32'h25);
        @(posedge clk); #1;
        ivalid = 1'b0;
        @(posedge clk); #1;
        check("lat_e3_ovalid", 32'(ovalid), 32'd0);
        @(posedge clk); #1;
        check("lat_e4_ovalid", 32'(ovalid), 32'd1);
        check("lat_e4_data", dataout, 32'h55);
        @(posedge clk); #1;
        check("lat_e5_ovalid", 32'(ovalid), 32'd1);
        check("lat_e5_data", dataout, 32'h25);
        @(posedge clk); #1;
        check("lat_e6_ovalid", 32'(ovalid), 32'd0);
        check("lat_e6_data", dataout, 32'h25);

        foreach (tbl[i]) drive(tbl[i].ivalid, tbl[i].data, tbl[i].iready, tbl[i].exp_oready, tbl[i].chk);
        check("fill_drained", 32'(sb.size()), 32'd0);
        check("fill_ovalid", 32'(ovalid), 32'd0);

        // Back-to-back stream: ovalid high for exactly 20 consecutive cycles.
        for (int j = 1; j <= 25; j++) begin
            ivalid = (j <= 20);
            datain = 32'h100 + 32'(j);
            iready = 1'b1;
            if (j <= 20) sb.push_back(datain);
            @(negedge clk);
            check("stream_oready", 32'(oready), 32'd1);
            check("stream_ovalid", 32'(ovalid), 32'((j >= 5) && (j <= 24)));
            @(posedge clk); #1;
        end
        check("stream_drained", 32'(sb.size()), 32'd0);

        // iready toggling each cycle while six words stream in.
        for (int j = 0; j < 16; j++) begin
            if (j < 6) drive(1'b1, 32'h200 + 32'(j), (j % 2 == 0), 1'b1, 1'b1);
            else       drive(1'b0, '0, (j % 2 == 0) || (j >= 12), 1'b1, 1'b0);
        end
        check("toggle_drained", 32'(sb.size()), 32'd0);
        check("toggle_ovalid", 32'(ovalid), 32'd0);

        // Reset with five words in flight discards all of them.
        for (int j = 0; j < 5; j++) drive(1'b1, 32'h300 + 32'(j), 1'b0, 1'b1, 1'b1);
        ivalid = 1'b0;
        check("pre_rst_ovalid", 32'(ovalid), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_ovalid", 32'(ovalid), 32'd0);
        check("mid_rst_dataout", dataout, 32'd0);
        check("mid_rst_oready", 32'(oready), 32'd0);
        sb.delete();
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("post_rst_oready", 32'(oready), 32'd1);
        drive(1'b1, 32'hA1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 32'hA2, 1'b1, 1'b1, 1'b1);
        for (int j = 0; j < 8; j++) drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("post_rst_drained", 32'(sb.size()), 32'd0);
        check("post_rst_ovalid", 32'(ovalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/argo_3stage.md
ARGO_3STAGE -- requirements
Module: argo_3stage

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits.
REQ-002 Parameter DEPTH, default 4: entries per internal channel FIFO; power of two, >= 2.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: reset, asynchronous, active-low.
REQ-005 ivalid  input  1: upstream word on datain is valid this cycle.
REQ-006 oready  output  1: module can accept a word this cycle.
REQ-007 datain  input  WIDTH: upstream data word.
REQ-008 ovalid  output  1: dataout holds a valid word.
REQ-009 iready  input  1: downstream accepts dataout this cycle.
REQ-010 dataout  output  WIDTH: downstream data word.

Function
REQ-011 The module SHALL model three concurrent processes joined by two channels: stage 1 (input, Y1) -> FIFO1 -> stage 2 (X1 register) -> FIFO2 -> stage 3 (output register Z1).
REQ-012 FIFO1 and FIFO2 SHALL each hold DEPTH words, be show-ahead (head readable combinationally), and keep an occupancy count of 0..DEPTH with full = (count==DEPTH) and empty = (count==0).
REQ-013 oready SHALL equal (not FIFO1 full) while rst is high, and 0 while rst is low.
REQ-014 Accept = ivalid AND oready at a rising edge; on accept, datain SHALL be written to the FIFO1 tail.
REQ-015 ivalid while oready=0 SHALL be ignored; the word is dropped and no state changes.
REQ-016 Stage 2 pop = FIFO1 not empty AND (x1_valid=0 OR push2); on pop, X1 <= FIFO1 head and x1_valid <= 1.
REQ-017 Stage 2 push2 = x1_valid AND (not FIFO2 full); on push2, X1 SHALL be written to the FIFO2 tail; x1_valid <= 0 unless a pop occurs in the same cycle.
REQ-018 Stage 3 load = FIFO2 not empty AND (ovalid=0 OR iready=1); on load, dataout <= FIFO2 head, ovalid <= 1, FIFO2 popped.
REQ-019 When ovalid=1, iready=1 and no load occurs, ovalid SHALL go 0; dataout SHALL keep its last value.
REQ-020 When ovalid=1 and iready=0, dataout and ovalid SHALL hold.
REQ-021 No FIFO SHALL push when full or pop when empty; no pass-through on full.
REQ-022 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 Latency: with iready held 1 and the pipe empty, a word accepted at edge k SHALL appear on dataout with ovalid=1 after edge k+3.
REQ-024 Throughput SHALL be one word per cycle in steady state.
REQ-025 Words SHALL be delivered in accept order, with no loss or duplication.
REQ-026 With iready=0, total storage SHALL be 2*DEPTH+2 words (10 at default); oready SHALL drop to 0 once FIFO1 is full.

Reset
REQ-027 While rst=0, asynchronously: both FIFOs empty (pointers and counts 0), x1_valid=0, X1=0, ovalid=0, dataout=0, oready=0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight words.
REQ-029 After rst rises, oready SHALL be 1 and normal operation SHALL start at the next rising edge.

Verification
REQ-030 After reset, iready=1; accept 0x55 at edge 1 and 0x25 at edge 2 -> dataout=0x55 with ovalid=1 after edge 4, dataout=0x25 after edge 5, then ovalid=0 after edge 6.
REQ-031 iready=0; drive ivalid=1 with words 1..12 -> exactly 10 accepted; oready=0 after the 10th; set iready=1 -> dataout 1..10 in order, then ovalid=0.
REQ-032 ivalid=1 with oready=0 (FIFO1 full) -> word not stored and not delivered.
REQ-033 Stream 20 consecutive words with iready=1 -> one output per cycle, in order, pointers wrap correctly.
REQ-034 Assert rst low with 5 words in flight -> ovalid=0, dataout=0, oready=0 immediately (asynchronously); after release, only new words are delivered.
REQ-035 Toggle iready 1,0,1,0 during a 6-word stream -> dataout held while iready=0, no loss, order preserved.
